// File: rtl/sid_i2s_pkg.sv
// sid_i2s_pkg: shared constants and slot-data helper for the SID I2S output stage
package sid_i2s_pkg;
   localparam int SAMPLE_W   = 16;
   localparam int SLOT_BITS  = 32;
   localparam int FRAME_BITS = 64;
   localparam int LR_RISE    = 31;
   localparam int LR_FALL    = 63;
   localparam int AVG_DEPTH  = 16;
   localparam int AVG_SHIFT  = 4;
   localparam int AVG_SUM_W  = 20;

   // First SAMPLE_W slots of each channel carry the word MSB first, the rest pad with zero
   function automatic logic slot_bit(input logic [SAMPLE_W-1:0] f, input logic [5:0] c);
      return (6'(c % SLOT_BITS) < 6'(SAMPLE_W)) ? f[~c[3:0]] : 1'b0;
   endfunction
endpackage

// File: rtl/sid_boxcar16.sv
// sid_boxcar16: 16-tap running-sum boxcar averager for the I2S source sample
module sid_boxcar16
   import sid_i2s_pkg::*;
(
   input  logic                clk,
   input  logic                iRst,
   input  logic                clkEn,
   input  logic [SAMPLE_W-1:0] iSample,
   output logic [SAMPLE_W-1:0] oAvg
);
   logic [SAMPLE_W-1:0]         hist [AVG_DEPTH];
   logic signed [AVG_SUM_W-1:0] sum;
   logic signed [AVG_SUM_W-1:0] add_ext, sub_ext;

   assign add_ext = {{(AVG_SUM_W-SAMPLE_W){iSample[SAMPLE_W-1]}}, iSample};
   assign sub_ext = {{(AVG_SUM_W-SAMPLE_W){hist[AVG_DEPTH-1][SAMPLE_W-1]}}, hist[AVG_DEPTH-1]};
   assign oAvg    = SAMPLE_W'(sum >>> AVG_SHIFT);

   // Shift history and keep the sum equal to the total of the last AVG_DEPTH samples
   always_ff @(posedge clk or posedge iRst)
      if (iRst) begin
         sum <= '0;
         for (int i = 0; i < AVG_DEPTH; i++) hist[i] <= '0;
      end else if (clkEn) begin
         hist[0] <= iSample;
         for (int i = 1; i < AVG_DEPTH; i++) hist[i] <= hist[i-1];
         sum <= sum + add_ext - sub_ext;
      end
endmodule

// File: rtl/sid_i2s_tx.sv
// sid_i2s_tx: Philips I2S transmitter for the mono SID mix; define SID_I2S_AVG_EN to insert the boxcar averager
module sid_i2s_tx
   import sid_i2s_pkg::*;
#(
   parameter int BCLK_DIV = 4
) (
   input  logic                clk,
   input  logic                iRst,
   input  logic                clkEn,
   input  logic [SAMPLE_W-1:0] iSample,
   output logic                oBclk,
   output logic                oLrclk,
   output logic                oSdata,
   output logic                oFrame
);
   localparam int DW = $clog2(BCLK_DIV);
   localparam int CW = $clog2(FRAME_BITS);

   logic [DW-1:0]       divCnt;
   logic [CW-1:0]       bitCnt, nextCnt;
   logic [SAMPLE_W-1:0] frame, src, nextFrame;
   logic                tick, fall, wrap;

   assign tick      = divCnt == DW'(BCLK_DIV-1);
   assign fall      = tick & oBclk;
   assign wrap      = fall & (bitCnt == CW'(LR_FALL));
   assign nextCnt   = bitCnt + CW'(1);
   assign nextFrame = wrap ? src : frame;

`ifdef SID_I2S_AVG_EN
   sid_boxcar16 u_avg (
      .clk     (clk),
      .iRst    (iRst),
      .clkEn   (clkEn),
      .iSample (iSample),
      .oAvg    (src)
   );
`else
   logic [SAMPLE_W-1:0] hold;

   assign src = hold;

   // Latest strobed sample waits here until the next frame latch
   always_ff @(posedge clk or posedge iRst)
      if (iRst) hold <= '0;
      else if (clkEn) hold <= iSample;
`endif

   // Bit clock divider: toggle BCLK every BCLK_DIV master cycles
   always_ff @(posedge clk or posedge iRst)
      if (iRst) begin
         divCnt <= '0;
         oBclk  <= 1'b0;
      end else begin
         divCnt <= tick ? '0 : divCnt + DW'(1);
         oBclk  <= oBclk ^ tick;
      end

   // Serial state advances on BCLK falls so LRCLK/SDATA are stable at every rise
   always_ff @(posedge clk or posedge iRst)
      if (iRst) begin
         bitCnt <= '0;
         frame  <= '0;
         oLrclk <= 1'b0;
         oSdata <= 1'b0;
         oFrame <= 1'b0;
      end else begin
         oFrame <= wrap;
         if (fall) begin
            bitCnt <= nextCnt;
            frame  <= nextFrame;
            oLrclk <= (nextCnt >= CW'(LR_RISE)) && (nextCnt < CW'(LR_FALL));
            oSdata <= slot_bit(nextFrame, nextCnt);
         end
      end
endmodule

// File: tb/tb_sid_i2s_tx.sv
// tb_sid_i2s_tx: directed self-checking bench for sid_i2s_tx and the sid_boxcar16 averager
module tb_sid_i2s_tx;
   logic        clk, iRst, clkEn;
   logic [15:0] iSample;
   logic        oBclk, oLrclk, oSdata, oFrame;
   logic        avg_en;
   logic [15:0] avg_sample, avg_out;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_frame_cyc;

   typedef struct {
      logic [15:0] sample;
      logic [63:0] sd;
   } vec_t;
   vec_t tv[6];

   localparam logic [63:0] LR_EXP = 64'h0000_0001_FFFF_FFFE;

   sid_i2s_tx #(.BCLK_DIV(4)) dut (
      .clk     (clk),
      .iRst    (iRst),
      .clkEn   (clkEn),
      .iSample (iSample),
      .oBclk   (oBclk),
      .oLrclk  (oLrclk),
      .oSdata  (oSdata),
      .oFrame  (oFrame)
   );

   sid_boxcar16 u_avg (
      .clk     (clk),
      .iRst    (iRst),
      .clkEn   (avg_en),
      .iSample (avg_sample),
      .oAvg    (avg_out)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic strobe_main(input logic [15:0] s);
      iSample = s;
      clkEn = 1;
      @(negedge clk);
      clkEn = 0;
   endtask

   task automatic strobe_avg(input logic [15:0] s);
      avg_sample = s;
      avg_en = 1;
      @(negedge clk);
      avg_en = 0;
   endtask

   task automatic wait_frame(output int ones);
      int n = 0;
      ones = 0;
      while (!oFrame && n < 2000) begin
         @(negedge clk);
         n++;
         if (oSdata && !oFrame) ones++;
      end
      chk("frame_seen", 64'(oFrame), 64'd1);
      chk("frame_gap", 64'(cyc - last_frame_cyc), 64'd512);
      last_frame_cyc = cyc;
   endtask

   task automatic collect(output logic [63:0] sd, output logic [63:0] lr);
      int r = 0;
      int n = 0;
      logic p;
      sd = '0;
      lr = '0;
      p = oBclk;
      while (r < 64 && n < 2000) begin
         @(negedge clk);
         n++;
         if (n == 1) chk("frame_width", 64'(oFrame), 64'd0);
         if (!p && oBclk) begin
            sd[63-r] = oSdata;
            lr[63-r] = oLrclk;
            r++;
         end
         p = oBclk;
      end
      chk("collect_done", 64'(r), 64'd64);
   endtask

   initial begin
      logic [63:0] sd, lr, prev;
      logic [7:0]  bseq;
      int          ones, n;

      tv[0] = '{16'h8001, 64'h8001_0000_8001_0000};
      tv[1] = '{16'hFFFF, 64'hFFFF_0000_FFFF_0000};
      tv[2] = '{16'h0000, 64'h0000_0000_0000_0000};
      tv[3] = '{16'hA5C3, 64'hA5C3_0000_A5C3_0000};
      tv[4] = '{16'h7FFE, 64'h7FFE_0000_7FFE_0000};
      tv[5] = '{16'h0001, 64'h0001_0000_0001_0000};

      iRst = 1; clkEn = 0; iSample = 0; avg_en = 0; avg_sample = 0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 64'({oBclk, oLrclk, oSdata, oFrame}), 64'd0);
      chk("avg_reset", 64'(avg_out), 64'h0);
      iRst = 0;
      last_frame_cyc = cyc;

      repeat (8) strobe_avg(16'h1000);
      chk("avg_step8", 64'(avg_out), 64'h0800);
      repeat (8) strobe_avg(16'h1000);
      chk("avg_step16", 64'(avg_out), 64'h1000);
      strobe_avg(16'hFFFF);
      chk("avg_neg1_partial", 64'(avg_out), 64'h0EFF);
      repeat (15) strobe_avg(16'h0000);
      chk("avg_neg_round", 64'(avg_out), 64'hFFFF);
      strobe_avg(16'h0000);
      chk("avg_clear", 64'(avg_out), 64'h0000);
      repeat (16) strobe_avg(16'h8000);
      chk("avg_min", 64'(avg_out), 64'h8000);
      repeat (16) strobe_avg(16'h7FFF);
      chk("avg_max", 64'(avg_out), 64'h7FFF);

      strobe_main(16'h8001);
      wait_frame(ones);
      n = 0;
      while (!(oLrclk && oBclk) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("midframe_reached", 64'(oLrclk && oBclk), 64'd1);
      #2 iRst = 1;
      #1 chk("async_reset", 64'({oBclk, oLrclk, oSdata, oFrame}), 64'd0);
      @(negedge clk);
      iRst = 0;
      last_frame_cyc = cyc;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1 bseq[7-k] = oBclk;
      end
      chk("bclk_start", 64'(bseq), 64'(8'b00011110));

      wait_frame(ones);
      chk("first_frame_zero", 64'(ones), 64'd0);
      prev = '0;
      for (int i = 0; i < 6; i++) begin
         collect(sd, lr);
         chk("frame_sd", sd, prev);
         chk("frame_lr", lr, LR_EXP);
         strobe_main(tv[i].sample);
         wait_frame(ones);
         prev = tv[i].sd;
      end
      collect(sd, lr);
      chk("frame_sd_last", sd, prev);

      wait_frame(ones);
      strobe_main(16'h0042);
      repeat (510) @(negedge clk);
      iSample = 16'h1234;
      clkEn = 1;
      @(negedge clk);
      clkEn = 0;
      chk("coincident_latch", 64'(oFrame), 64'd1);
      last_frame_cyc = cyc;
      collect(sd, lr);
      chk("coincident_old", sd, 64'h0042_0000_0042_0000);
      wait_frame(ones);
      collect(sd, lr);
      chk("coincident_new", sd, 64'h1234_0000_1234_0000);
      chk("coincident_lr", lr, LR_EXP);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
